node_packet_interface: RTL and testbench
========================================

NODE_PACKET_INTERFACE -- requirements
Module: node_packet_interface

Interface
- REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  - COORD_BITS, 1, router x/y coordinate width.
  - MULTICAST_GROUP_BITS, 1, multicast group width.
  - MATRIX_TYPE_BITS, 1, matrix type width.
  - MATRIX_COORD_BITS, 8, matrix coordinate width.
  - MATRIX_ELEMENT_BITS, 32, matrix element width.
  - FIFO_DEPTH, 4, TX and RX FIFO depth; power of 2, minimum 2.
- REQ-002 PACKET_BITS SHALL equal 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS (54 at defaults).
- REQ-003 Packet layout SHALL be, MSB to LSB: x_coord, y_coord, multicast_group, done_flag, result_flag, matrix_type, matrix_x_coord, matrix_y_coord, matrix_element.
- REQ-004 Ports, one per line as name, direction, width, meaning:
  - clk  in  1  clock.
  - reset_n  in  1  reset, synchronous, active-low.
  - <f>_in, <f>_in_valid  in  field width, 1  node field write, one pair per packet field f in REQ-003.
  - packet_complete_in  in  1  push the staged packet.
  - message_out_ready  out  1  TX FIFO not full.
  - tx_packet, tx_valid  out  PACKET_BITS, 1  toward the router.
  - tx_ready  in  1  router accepts tx_packet.
  - rx_packet, rx_valid  in  PACKET_BITS, 1  from the router.
  - rx_ready  out  1  RX FIFO not full.
  - <g>_out  out  field width  RX FIFO head field, for each field g except x_coord and y_coord.
  - message_in_available, message_in_valid  out  1, 1  RX status.
  - message_in_read  in  1  pop the RX head.
  - tx_overflow, field_error  out  1, 1  single-cycle error pulses.

Function
- REQ-005 A field strobe SHALL load its staging register on that clk edge; staged values SHALL persist across pushes.
- REQ-006 A field strobe and packet_complete_in in the same cycle SHALL push the new field value (bypass).
- REQ-007 packet_complete_in with TX count < FIFO_DEPTH SHALL push the staged packet; tx_valid SHALL rise the next cycle if the FIFO was empty.
- REQ-008 packet_complete_in with TX full SHALL drop the packet and pulse tx_overflow for 1 cycle; fullness SHALL be judged on the start-of-cycle count, even if a pop occurs in the same cycle.
- REQ-009 message_out_ready SHALL equal (TX count < FIFO_DEPTH); tx_valid SHALL equal (TX count != 0).
- REQ-010 Pop SHALL occur on tx_valid && tx_ready; tx_packet SHALL hold stable while tx_valid && !tx_ready; order SHALL be FIFO.
- REQ-011 rx_ready SHALL equal (RX count < FIFO_DEPTH); push SHALL occur on rx_valid && rx_ready.
- REQ-012 message_in_available SHALL equal (RX count != 0); the <g>_out fields SHALL present the head entry combinationally from storage.
- REQ-013 message_in_valid SHALL equal message_in_available && !(message_in_read in the previous cycle), guaranteeing the head has settled after a pop.
- REQ-014 message_in_read SHALL pop one entry; a read while empty SHALL be ignored; a simultaneous RX push and pop SHALL leave the count unchanged.
- REQ-015 Pointers SHALL be log2(FIFO_DEPTH) bits wrapping modulo depth; counts SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
- REQ-016 With reset_n low at a clk edge:
  - both FIFOs SHALL be emptied, discarding any in-flight packets;
  - staging registers and the field mask SHALL be cleared;
  - tx_overflow and field_error SHALL be 0.
- REQ-017 message_out_ready and rx_ready SHALL be 0 while reset_n is low and 1 in the first cycle after release.

Configuration
- REQ-018 With NPI_FIELD_CHECK_EN defined:
  - a written-mask SHALL track x_coord, y_coord and matrix_element strobes since the last packet_complete_in;
  - packet_complete_in with any of these unwritten SHALL not push and SHALL pulse field_error;
  - the mask SHALL clear on every packet_complete_in.
- REQ-019 Without NPI_FIELD_CHECK_EN, field_error SHALL be tied 0 and no mask logic SHALL exist.

Verification
- REQ-020 Write x=1, y=0, element=0xDEADBEEF, then complete; tx_ready=1 -> tx_valid for 1 cycle with tx_packet[31:0]=0xDEADBEEF and bit53=1.
- REQ-021 tx_ready=0, 5 completes -> 4 entries stored, message_out_ready=0, one tx_overflow pulse; releasing tx_ready drains 4 packets in order.
- REQ-022 Element strobe 0x5 in the same cycle as complete, prior staged value 0x9 -> pushed element=0x5.
- REQ-023 4 rx packets -> rx_ready=0; one read -> message_in_valid=0 for 1 cycle, then 1 with the second packet's element on matrix_element_out.
- REQ-024 reset_n low with 3 TX and 2 RX entries -> tx_valid=0, message_in_available=0, ready signals 1 after release.
- REQ-025 NPI_FIELD_CHECK_EN: complete without a y write -> no push and a field_error pulse; without the macro -> push occurs.

Source files
------------

// File: rtl/node_packet_interface.sv
// Node-side packet interface: stages packet fields, queues packets toward the router (TX FIFO)
// and buffers packets from the router (RX FIFO). Define NPI_FIELD_CHECK_EN to enable the written-field check.
module node_packet_interface #(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int FIFO_DEPTH           = 4,
    localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                               + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [COORD_BITS-1:0]           x_coord_in,
    input  logic                            x_coord_in_valid,
    input  logic [COORD_BITS-1:0]           y_coord_in,
    input  logic                            y_coord_in_valid,
    input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
    input  logic                            multicast_group_in_valid,
    input  logic                            done_flag_in,
    input  logic                            done_flag_in_valid,
    input  logic                            result_flag_in,
    input  logic                            result_flag_in_valid,
    input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
    input  logic                            matrix_type_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
    input  logic                            matrix_x_coord_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
    input  logic                            matrix_y_coord_in_valid,
    input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
    input  logic                            matrix_element_in_valid,
    input  logic                            packet_complete_in,
    output logic                            message_out_ready,
    output logic [PACKET_BITS-1:0]          tx_packet,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    input  logic [PACKET_BITS-1:0]          rx_packet,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [MULTICAST_GROUP_BITS-1:0] multicast_group_out,
    output logic                            done_flag_out,
    output logic                            result_flag_out,
    output logic [MATRIX_TYPE_BITS-1:0]     matrix_type_out,
    output logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_out,
    output logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_out,
    output logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_out,
    output logic                            message_in_available,
    output logic                            message_in_valid,
    input  logic                            message_in_read,
    output logic                            tx_overflow,
    output logic                            field_error
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MY_LSB  = MATRIX_ELEMENT_BITS;
    localparam int MX_LSB  = MY_LSB + MATRIX_COORD_BITS;
    localparam int MT_LSB  = MX_LSB + MATRIX_COORD_BITS;
    localparam int RES_BIT = MT_LSB + MATRIX_TYPE_BITS;
    localparam int DON_BIT = RES_BIT + 1;
    localparam int MG_LSB  = DON_BIT + 1;
    localparam int Y_LSB   = MG_LSB + MULTICAST_GROUP_BITS;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [COORD_BITS-1:0]           x_stage_r, y_stage_r;
    logic [MULTICAST_GROUP_BITS-1:0] mg_stage_r;
    logic                            done_stage_r, res_stage_r;
    logic [MATRIX_TYPE_BITS-1:0]     mt_stage_r;
    logic [MATRIX_COORD_BITS-1:0]    mx_stage_r, my_stage_r;
    logic [MATRIX_ELEMENT_BITS-1:0]  me_stage_r;
    logic [PACKET_BITS-1:0]          staged_pkt_s;

    logic [PACKET_BITS-1:0] tx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       tx_wr_ptr_r, tx_rd_ptr_r;
    logic [CNT_W-1:0]       tx_count_r;
    logic                   tx_push_s, tx_pop_s, tx_full_s, fields_ok_s;

    logic [PACKET_BITS-1:0] rx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CNT_W-1:0]       rx_count_r;
    logic                   rx_push_s, rx_pop_s, read_d_r, tx_overflow_r;
    logic [PACKET_BITS-1:0] rx_head_s;
    logic                   rx_coord_unused_s;

    // Field strobes bypass staging so a strobe coincident with complete is pushed.
    assign staged_pkt_s = {
        x_coord_in_valid        ? x_coord_in        : x_stage_r,
        y_coord_in_valid        ? y_coord_in        : y_stage_r,
        multicast_group_in_valid ? multicast_group_in : mg_stage_r,
        done_flag_in_valid      ? done_flag_in      : done_stage_r,
        result_flag_in_valid    ? result_flag_in    : res_stage_r,
        matrix_type_in_valid    ? matrix_type_in    : mt_stage_r,
        matrix_x_coord_in_valid ? matrix_x_coord_in : mx_stage_r,
        matrix_y_coord_in_valid ? matrix_y_coord_in : my_stage_r,
        matrix_element_in_valid ? matrix_element_in : me_stage_r
    };

    // Staging registers: load on strobe, persist across pushes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_stage_r    <= '0;
            y_stage_r    <= '0;
            mg_stage_r   <= '0;
            done_stage_r <= 1'b0;
            res_stage_r  <= 1'b0;
            mt_stage_r   <= '0;
            mx_stage_r   <= '0;
            my_stage_r   <= '0;
            me_stage_r   <= '0;
        end else begin
            {x_stage_r, y_stage_r, mg_stage_r, done_stage_r, res_stage_r,
             mt_stage_r, mx_stage_r, my_stage_r, me_stage_r} <= staged_pkt_s;
        end
    end

`ifdef NPI_FIELD_CHECK_EN
    logic [2:0] mask_r, mask_now_s;
    logic       field_error_r;
    assign mask_now_s  = mask_r | {x_coord_in_valid, y_coord_in_valid, matrix_element_in_valid};
    assign fields_ok_s = &mask_now_s;
    assign field_error = field_error_r;

    // Written-mask of mandatory fields since the last complete, plus the error pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_r        <= 3'b000;
            field_error_r <= 1'b0;
        end else begin
            mask_r        <= packet_complete_in ? 3'b000 : mask_now_s;
            field_error_r <= packet_complete_in && !fields_ok_s;
        end
    end
`else
    assign fields_ok_s = 1'b1;
    assign field_error = 1'b0;
`endif

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop does not rescue a push.
    assign tx_full_s         = (tx_count_r >= DEPTH_C);
    assign tx_push_s         = packet_complete_in && fields_ok_s && !tx_full_s;
    assign tx_pop_s          = tx_valid && tx_ready;
    assign tx_valid          = (tx_count_r != '0);
    assign tx_packet         = tx_mem_r[tx_rd_ptr_r];
    assign message_out_ready = reset_n && !tx_full_s;
    assign tx_overflow       = tx_overflow_r;

    // TX FIFO state and overflow pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wr_ptr_r   <= '0;
            tx_rd_ptr_r   <= '0;
            tx_count_r    <= '0;
            tx_overflow_r <= 1'b0;
        end else begin
            tx_overflow_r <= packet_complete_in && fields_ok_s && tx_full_s;
            if (tx_push_s) begin
                tx_mem_r[tx_wr_ptr_r] <= staged_pkt_s;
                tx_wr_ptr_r           <= tx_wr_ptr_r + PTR_W'(1);
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_W'(1);
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_W'(1);
                2'b01:   tx_count_r <= tx_count_r - CNT_W'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    assign rx_ready             = reset_n && (rx_count_r < DEPTH_C);
    assign rx_push_s            = rx_valid && rx_ready;
    assign rx_pop_s             = message_in_read && (rx_count_r != '0);
    assign message_in_available = (rx_count_r != '0);
    assign message_in_valid     = message_in_available && !read_d_r;

    // RX FIFO state; read_d_r masks the head for one cycle after a read while it settles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_count_r  <= '0;
            read_d_r    <= 1'b0;
        end else begin
            read_d_r <= message_in_read;
            if (rx_push_s) begin
                rx_mem_r[rx_wr_ptr_r] <= rx_packet;
                rx_wr_ptr_r           <= rx_wr_ptr_r + PTR_W'(1);
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_W'(1);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_W'(1);
                2'b01:   rx_count_r <= rx_count_r - CNT_W'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // The node already knows its own coordinates, so the head's x/y are not presented.
    assign rx_head_s           = rx_mem_r[rx_rd_ptr_r];
    assign rx_coord_unused_s   = ^rx_head_s[PACKET_BITS-1:Y_LSB];
    assign multicast_group_out = rx_head_s[MG_LSB +: MULTICAST_GROUP_BITS];
    assign done_flag_out       = rx_head_s[DON_BIT];
    assign result_flag_out     = rx_head_s[RES_BIT];
    assign matrix_type_out     = rx_head_s[MT_LSB +: MATRIX_TYPE_BITS];
    assign matrix_x_coord_out  = rx_head_s[MX_LSB +: MATRIX_COORD_BITS];
    assign matrix_y_coord_out  = rx_head_s[MY_LSB +: MATRIX_COORD_BITS];
    assign matrix_element_out  = rx_head_s[MATRIX_ELEMENT_BITS-1:0];
endmodule

// File: tb/tb_node_packet_interface.sv
// Bench for node_packet_interface: directed scenarios then random traffic, checked
// against a queue-based reference model. Honours NPI_FIELD_CHECK_EN like the design.
module tb_node_packet_interface;
    localparam int D  = 4;
    localparam int PB = 54;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [31:0]   fin  [9];
    logic          fval [9];
    logic          complete, tx_ready, rx_valid, rd;
    logic [PB-1:0] rx_packet;

    logic          message_out_ready, tx_valid, rx_ready;
    logic [PB-1:0] tx_packet;
    logic          mg_out, done_out, res_out, mt_out;
    logic [7:0]    mx_out, my_out;
    logic [31:0]   me_out;
    logic          avail, mvalid, tx_overflow, field_error;

    node_packet_interface dut (
        .clk(clk), .reset_n(reset_n),
        .x_coord_in(fin[0][0]),        .x_coord_in_valid(fval[0]),
        .y_coord_in(fin[1][0]),        .y_coord_in_valid(fval[1]),
        .multicast_group_in(fin[2][0]), .multicast_group_in_valid(fval[2]),
        .done_flag_in(fin[3][0]),      .done_flag_in_valid(fval[3]),
        .result_flag_in(fin[4][0]),    .result_flag_in_valid(fval[4]),
        .matrix_type_in(fin[5][0]),    .matrix_type_in_valid(fval[5]),
        .matrix_x_coord_in(fin[6][7:0]), .matrix_x_coord_in_valid(fval[6]),
        .matrix_y_coord_in(fin[7][7:0]), .matrix_y_coord_in_valid(fval[7]),
        .matrix_element_in(fin[8]),    .matrix_element_in_valid(fval[8]),
        .packet_complete_in(complete), .message_out_ready(message_out_ready),
        .tx_packet(tx_packet), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_packet(rx_packet), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .multicast_group_out(mg_out), .done_flag_out(done_out), .result_flag_out(res_out),
        .matrix_type_out(mt_out), .matrix_x_coord_out(mx_out), .matrix_y_coord_out(my_out),
        .matrix_element_out(me_out), .message_in_available(avail), .message_in_valid(mvalid),
        .message_in_read(rd), .tx_overflow(tx_overflow), .field_error(field_error)
    );

    // Reference model state
    logic [PB-1:0] txq [$];
    logic [PB-1:0] rxq [$];
    logic [31:0]   stage [9];
    logic          mask [3];
    logic          ovf_e, ferr_e, rd_prev;
    int            compared, mismatched;
    logic [PB-1:0] saved [4];

    function automatic logic [PB-1:0] pack(input logic [31:0] f [9]);
        return {f[0][0], f[1][0], f[2][0], f[3][0], f[4][0], f[5][0], f[6][7:0], f[7][7:0], f[8]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [PB-1:0] h;
        chk("message_out_ready", 64'(message_out_ready), 64'(reset_n && txq.size() < D));
        chk("rx_ready", 64'(rx_ready), 64'(reset_n && rxq.size() < D));
        chk("tx_valid", 64'(tx_valid), 64'(txq.size() != 0));
        chk("message_in_available", 64'(avail), 64'(rxq.size() != 0));
        chk("message_in_valid", 64'(mvalid), 64'(rxq.size() != 0 && !rd_prev));
        chk("tx_overflow", 64'(tx_overflow), 64'(ovf_e));
        chk("field_error", 64'(field_error), 64'(ferr_e));
        if (txq.size() != 0) chk("tx_packet", 64'(tx_packet), 64'(txq[0]));
        if (rxq.size() != 0) begin
            h = rxq[0];
            chk("rx_head", {mg_out, done_out, res_out, mt_out, mx_out, my_out, me_out}, 64'(h[51:0]));
        end
    endtask

    // Apply the edge to the model from the currently driven inputs, then let the DUT clock.
    task automatic tick();
        logic [31:0] eff [9];
        logic ok;
        int txs, rxs;
        txs = txq.size();
        rxs = rxq.size();
        for (int i = 0; i < 9; i++) eff[i] = fval[i] ? fin[i] : stage[i];
        if (!reset_n) begin
            txq.delete();
            rxq.delete();
            for (int i = 0; i < 9; i++) stage[i] = 32'd0;
            for (int i = 0; i < 3; i++) mask[i] = 1'b0;
            ovf_e = 1'b0; ferr_e = 1'b0; rd_prev = 1'b0;
        end else begin
            ok = 1'b1;
`ifdef NPI_FIELD_CHECK_EN
            ok = (mask[0] | fval[0]) & (mask[1] | fval[1]) & (mask[2] | fval[8]);
            if (complete) begin
                for (int i = 0; i < 3; i++) mask[i] = 1'b0;
            end else begin
                mask[0] = mask[0] | fval[0];
                mask[1] = mask[1] | fval[1];
                mask[2] = mask[2] | fval[8];
            end
`endif
            ovf_e = 1'b0; ferr_e = 1'b0;
            if (txs != 0 && tx_ready) void'(txq.pop_front());
            if (complete) begin
                if (!ok) ferr_e = 1'b1;
                else if (txs < D) txq.push_back(pack(eff));
                else ovf_e = 1'b1;
            end
            if (rd && rxs != 0) void'(rxq.pop_front());
            if (rx_valid && rxs < D) rxq.push_back(rx_packet);
            for (int i = 0; i < 9; i++) stage[i] = eff[i];
            rd_prev = rd;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr();
        for (int i = 0; i < 9; i++) fval[i] = 1'b0;
        complete = 1'b0; rx_valid = 1'b0; rd = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] v);
        fin[idx]  = v;
        fval[idx] = 1'b1;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        for (int i = 0; i < 9; i++) begin fin[i] = 32'd0; stage[i] = 32'd0; end
        for (int i = 0; i < 3; i++) mask[i] = 1'b0;
        ovf_e = 1'b0; ferr_e = 1'b0; rd_prev = 1'b0;
        rx_packet = '0; tx_ready = 1'b0;
        clr();

        // Reset, then release
        reset_n = 1'b0;
        tick(); tick();
        chk("ready_in_reset", 64'({message_out_ready, rx_ready}), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_release", 64'({message_out_ready, rx_ready}), 64'd3);

        // Basic push: x=1, y=0, element DEADBEEF
        wr(0, 32'd1); tick(); clr();
        wr(1, 32'd0); tick(); clr();
        wr(8, 32'hDEADBEEF); tick(); clr();
        tx_ready = 1'b1; complete = 1'b1; tick(); clr();
        chk("basic_valid", 64'(tx_valid), 64'd1);
        chk("basic_element", 64'(tx_packet[31:0]), 64'hDEADBEEF);
        chk("basic_x_bit53", 64'(tx_packet[53]), 64'd1);
        tick();
        chk("basic_valid_drop", 64'(tx_valid), 64'd0);

        // Overflow: five completes into a stalled FIFO
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clr(); wr(0, 32'(k & 1)); wr(1, 32'd1); wr(8, 32'h100 + 32'(k)); complete = 1'b1;
            tick();
        end
        clr();
        chk("ovf_pulse", 64'(tx_overflow), 64'd1);
        chk("ovf_not_ready", 64'(message_out_ready), 64'd0);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", 64'(tx_packet[31:0]), 64'h100 + 64'(k));
            tick();
        end
        chk("drain_empty", 64'(tx_valid), 64'd0);

        // Bypass: strobe coincident with complete wins over staged value
        tx_ready = 1'b0;
        wr(8, 32'h9); tick(); clr();
        wr(0, 32'd0); wr(1, 32'd1); wr(8, 32'h5); complete = 1'b1; tick(); clr();
        chk("bypass_element", 64'(tx_packet[31:0]), 64'h5);
        tx_ready = 1'b1; tick();

        // RX: fill, then one read
        for (int k = 0; k < 4; k++) begin
            saved[k] = {22'($urandom), $urandom};
            rx_packet = saved[k]; rx_valid = 1'b1; tick();
        end
        clr();
        chk("rx_full", 64'(rx_ready), 64'd0);
        rd = 1'b1; tick(); clr();
        chk("rx_settle", 64'(mvalid), 64'd0);
        tick();
        chk("rx_valid_again", 64'(mvalid), 64'd1);
        chk("rx_second_elem", 64'(me_out), 64'(saved[1][31:0]));
        rd = 1'b1; tick(); tick(); tick(); clr();

        // Reset with traffic in flight
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr(); wr(0, 32'd1); wr(1, 32'd0); wr(8, 32'(k)); complete = 1'b1;
            rx_packet = {22'($urandom), $urandom}; rx_valid = (k < 2);
            tick();
        end
        clr();
        reset_n = 1'b0; tick();
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_avail", 64'(avail), 64'd0);
        reset_n = 1'b1; tick();
        chk("rst_release_ready", 64'({message_out_ready, rx_ready}), 64'd3);

        // Missing y write
        wr(0, 32'd1); wr(8, 32'h7); complete = 1'b1; tick(); clr();
`ifdef NPI_FIELD_CHECK_EN
        chk("fchk_error", 64'(field_error), 64'd1);
        chk("fchk_no_push", 64'(tx_valid), 64'd0);
`else
        chk("nochk_error", 64'(field_error), 64'd0);
        chk("nochk_push", 64'(tx_valid), 64'd1);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 9; i++) begin
                fin[i]  = $urandom;
                fval[i] = ($urandom_range(0, 2) != 0);
            end
            complete  = ($urandom_range(0, 2) == 0);
            tx_ready  = ($urandom_range(0, 2) == 0);
            rx_valid  = ($urandom_range(0, 1) == 0);
            rx_packet = {22'($urandom), $urandom};
            rd        = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
